// File: rtl/hermes_src_arbiter_pkg.sv
// Shared types and constants for the Hermes source arbiter and related muxes.
package hermes_src_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        SIZE    = 2'd2,
        PAYLOAD = 2'd3
    } arb_state_t;

    // Header flit plus size flit precede every payload.
    localparam int HERMES_HDR_FLITS = 2;

endpackage

// File: rtl/hermes_src_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_i, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] grant_o,
    output logic         valid_o
);

    logic [W-1:0] idx;

    always_comb begin
        grant_o = last_i;
        valid_o = 1'b0;
        idx     = '0;
        // Offset 1..N so the previous owner is searched last.
        for (int i = 1; i <= N; i++) begin
            idx = W'((int'(last_i) + i) % N);
            if (!valid_o && req_i[idx]) begin
                grant_o = idx;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hermes_src_arbiter.sv
// Packet-atomic round-robin merge of N_SRC Hermes flit streams onto one link.
// Optional per-source packet counters: define HERMES_SRC_ARBITER_STATS_EN.
module hermes_src_arbiter
    import hermes_src_arbiter_pkg::*;
#(
    parameter int N_SRC     = 2,
    parameter int FLIT_SIZE = 32,
    parameter int SIZE_W    = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_SRC-1:0]                    src_rx_i,
    output logic [N_SRC-1:0]                    src_credit_o,
    input  logic [N_SRC-1:0][FLIT_SIZE-1:0]     src_data_i,
    output logic                                dst_tx_o,
    input  logic                                dst_credit_i,
    output logic [FLIT_SIZE-1:0]                dst_data_o,
    output logic [$clog2(N_SRC)-1:0]            grant_o,
    output logic                                busy_o
`ifdef HERMES_SRC_ARBITER_STATS_EN
    ,
    output logic [N_SRC-1:0][31:0]              pkt_count_o
`endif
);

    localparam int GW = $clog2(N_SRC);

    arb_state_t        state_q, state_d;
    logic [SIZE_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic              busy_q, busy_d;

    logic [GW-1:0]     arb_grant;
    logic              arb_valid;
    logic              xfer;
    logic [SIZE_W-1:0] size_val;

    rr_arbiter #(.N(N_SRC)) u_rr (
        .req_i   (src_rx_i),
        .last_i  (grant_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    // Owner path is combinational so a granted source sees zero added latency.
    always_comb begin
        dst_tx_o     = 1'b0;
        dst_data_o   = '0;
        src_credit_o = '0;
        if (state_q != IDLE) begin
            dst_tx_o              = src_rx_i[grant_q];
            dst_data_o            = src_data_i[grant_q];
            src_credit_o[grant_q] = dst_credit_i;
        end
    end

    assign xfer     = dst_tx_o && dst_credit_i;
    assign size_val = dst_data_o[SIZE_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (xfer) state_d = SIZE;
            end
            SIZE: begin
                if (xfer) begin
                    cnt_d   = size_val;
                    state_d = (size_val == '0) ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q - SIZE_W'(1);
                    if (cnt_q == SIZE_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= GW'(N_SRC - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

`ifdef HERMES_SRC_ARBITER_STATS_EN
    logic [N_SRC-1:0][31:0] pkt_cnt_q, pkt_cnt_d;
    logic                   pkt_done;

    assign pkt_done = xfer && (((state_q == SIZE) && (size_val == '0)) ||
                               ((state_q == PAYLOAD) && (cnt_q == SIZE_W'(1))));

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (pkt_done) pkt_cnt_d[grant_q] = pkt_cnt_q[grant_q] + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pkt_cnt_q <= '0;
        else         pkt_cnt_q <= pkt_cnt_d;
    end

    assign pkt_count_o = pkt_cnt_q;
`endif

endmodule
